dm_cache_ctrl: RTL and testbench

Parametrised direct-mapped, write-back, write-allocate cache controller for the memory sub-system. It replaces the bare line array with tag/valid/dirty tracking, a CPU-side request/response handshake and a memory-side line-transfer handshake. It sits between the core's load/store port and the main-memory model, with one outstanding CPU request at a time.

---
 rtl/memory_sub_system_param.sv | 20 ++
 rtl/dm_cache_tag_store.sv | 48 ++++
 rtl/dm_cache_ctrl.sv | 147 ++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_sub_system_param.sv
// memory_sub_system_param: shared cache types, default geometry and width helpers.
package memory_sub_system_param;
    localparam int ADDR_WIDTH    = 32;
    localparam int INDEX_LENGTH  = 4;
    localparam int OFFSET_LENGTH = 2;
    localparam int WORD_SIZE     = 32;
    localparam int LINE_SIZE     = WORD_SIZE << OFFSET_LENGTH;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, RESPOND} state_t;

    typedef logic [LINE_SIZE-1:0] line_t;

    function automatic int tag_w(input int addr_w, input int index_len, input int offset_len);
        return addr_w - index_len - offset_len;
    endfunction

    function automatic int line_w(input int word_s, input int offset_len);
        return word_s << offset_len;
    endfunction
endpackage

// File: rtl/dm_cache_tag_store.sv
// dm_cache_tag_store: per-line valid/dirty/tag tracking; valid and dirty clear on reset.
module dm_cache_tag_store #(
    parameter int INDEX_LEN = 4,
    parameter int TAG_W     = 26
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [INDEX_LEN-1:0] lk_index,
    output logic                 lk_valid,
    output logic                 lk_dirty,
    output logic [TAG_W-1:0]     lk_tag,
    input  logic                 upd_en,
    input  logic [INDEX_LEN-1:0] upd_index,
    input  logic                 upd_dirty,
    input  logic [TAG_W-1:0]     upd_tag
);
    localparam int LINES = 1 << INDEX_LEN;

    logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q [LINES];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (upd_en) begin
            valid_d[upd_index] = 1'b1;
            dirty_d[upd_index] = upd_dirty;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_en) tag_q[upd_index] <= upd_tag;
    end

    assign lk_valid = valid_q[lk_index];
    assign lk_dirty = dirty_q[lk_index];
    assign lk_tag   = tag_q[lk_index];
endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-back/write-allocate cache, one CPU request in flight.
module dm_cache_ctrl
    import memory_sub_system_param::*;
#(
    parameter int ADDR_W     = ADDR_WIDTH,
    parameter int INDEX_LEN  = INDEX_LENGTH,
    parameter int OFFSET_LEN = OFFSET_LENGTH,
    parameter int WORD_S     = WORD_SIZE
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             cpu_req_valid,
    output logic                             cpu_req_ready,
    input  logic                             cpu_req_write,
    input  logic [ADDR_W-1:0]                cpu_req_addr,
    input  logic [WORD_S-1:0]                cpu_req_wdata,
    output logic                             cpu_resp_valid,
    output logic [WORD_S-1:0]                cpu_resp_rdata,
    output logic                             cpu_resp_hit,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic                             mem_req_write,
    output logic [ADDR_W-1:0]                mem_req_addr,
    output logic [(WORD_S<<OFFSET_LEN)-1:0]  mem_req_wdata,
    input  logic                             mem_resp_valid,
    input  logic [(WORD_S<<OFFSET_LEN)-1:0]  mem_resp_rdata
);
    localparam int LINE_W = line_w(WORD_S, OFFSET_LEN);
    localparam int TAG_W  = tag_w(ADDR_W, INDEX_LEN, OFFSET_LEN);
    localparam int LINES  = 1 << INDEX_LEN;

    state_t state_q, state_d;
    logic              write_q, write_d, miss_q, miss_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_S-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [LINE_W-1:0] data_q [LINES];

    logic [TAG_W-1:0]      tag_r, lk_tag, upd_tag;
    logic [INDEX_LEN-1:0]  idx_r;
    logic [OFFSET_LEN-1:0] off_r;
    logic                  lk_valid, lk_dirty, hit, upd_en, upd_dirty, data_we;
    logic [LINE_W-1:0]     line_r, merged, data_wline;
    logic [WORD_S-1:0]     word_r;

    assign tag_r  = addr_q[ADDR_W-1 -: TAG_W];
    assign idx_r  = addr_q[OFFSET_LEN +: INDEX_LEN];
    assign off_r  = addr_q[OFFSET_LEN-1:0];
    assign line_r = data_q[idx_r];
    assign word_r = line_r[off_r*WORD_S +: WORD_S];
    assign hit    = lk_valid && (lk_tag == tag_r);

    always_comb begin
        merged = line_r;
        merged[off_r*WORD_S +: WORD_S] = wdata_q;
    end

    dm_cache_tag_store #(.INDEX_LEN(INDEX_LEN), .TAG_W(TAG_W)) u_tags (
        .clk      (clk),
        .resetn   (resetn),
        .lk_index (idx_r),
        .lk_valid (lk_valid),
        .lk_dirty (lk_dirty),
        .lk_tag   (lk_tag),
        .upd_en   (upd_en),
        .upd_index(idx_r),
        .upd_dirty(upd_dirty),
        .upd_tag  (upd_tag)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            miss_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            miss_q  <= miss_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[idx_r] <= data_wline;
    end

    // After a fill the FSM re-enters LOOKUP, so stores merge through the normal hit path
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        miss_d     = miss_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        upd_en     = 1'b0;
        upd_dirty  = 1'b0;
        upd_tag    = tag_r;
        data_we    = 1'b0;
        data_wline = merged;
        case (state_q)
            IDLE: if (cpu_req_valid) begin
                state_d = LOOKUP;
                write_d = cpu_req_write;
                addr_d  = cpu_req_addr;
                wdata_d = cpu_req_wdata;
                miss_d  = 1'b0;
            end
            LOOKUP: if (hit) begin
                state_d   = RESPOND;
                rdata_d   = write_q ? wdata_q : word_r;
                upd_en    = write_q;
                upd_dirty = 1'b1;
                data_we   = write_q;
            end else begin
                miss_d  = 1'b1;
                state_d = (lk_valid && lk_dirty) ? WB_REQ : FILL_REQ;
            end
            WB_REQ:    state_d = mem_req_ready ? FILL_REQ : WB_REQ;
            FILL_REQ:  state_d = mem_req_ready ? FILL_WAIT : FILL_REQ;
            FILL_WAIT: if (mem_resp_valid) begin
                state_d    = LOOKUP;
                upd_en     = 1'b1;
                data_we    = 1'b1;
                data_wline = mem_resp_rdata;
            end
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_req_ready  = state_q == IDLE;
        cpu_resp_valid = state_q == RESPOND;
        cpu_resp_rdata = (state_q == RESPOND) ? rdata_q : '0;
        cpu_resp_hit   = (state_q == RESPOND) && !miss_q;
        mem_req_valid  = (state_q == WB_REQ) || (state_q == FILL_REQ);
        mem_req_write  = state_q == WB_REQ;
        mem_req_addr   = (state_q == WB_REQ)   ? {lk_tag, idx_r, {OFFSET_LEN{1'b0}}} :
                         (state_q == FILL_REQ) ? {tag_r, idx_r, {OFFSET_LEN{1'b0}}} : '0;
        mem_req_wdata  = (state_q == WB_REQ) ? line_r : '0;
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: random and directed traffic against a behavioural cache/memory model.
module tb_dm_cache_ctrl;
    logic         clk = 1'b0;
    logic         resetn;
    logic         cpu_req_valid, cpu_req_ready, cpu_req_write;
    logic [15:0]  cpu_req_addr;
    logic [31:0]  cpu_req_wdata;
    logic         cpu_resp_valid, cpu_resp_hit;
    logic [31:0]  cpu_resp_rdata;
    logic         mem_req_valid, mem_req_ready, mem_req_write;
    logic [15:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_rdata;

    dm_cache_ctrl #(.ADDR_W(16), .INDEX_LEN(4), .OFFSET_LEN(2), .WORD_S(32)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_hit(cpu_resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct { bit w; logic [15:0] a; logic [127:0] d; } mreq_t;
    typedef struct { logic [31:0] rd; bit hit; } resp_t;
    mreq_t expm[$];
    resp_t expr[$];

    // Model: cache contents per index plus a sparse main memory
    bit           mv[16], mdirt[16];
    logic [9:0]   mt[16];
    logic [127:0] mdat[16];
    logic [127:0] mmem [logic [15:0]];

    int resp_cnt = 0, force_low = 0, acc_edge = 0, fill_edge = 0, fill_delay = 0;
    bit spur_req = 0, long_fill = 0, fill_pend = 0, first_pending = 0, prev_stall = 0, prev_resp = 0;
    logic [15:0]  fill_addr, last_fill_addr, last_wb_addr, prev_addr;
    logic [127:0] last_wb_data, prev_wdata;
    logic [31:0]  last_rdata;
    logic         last_hit, prev_write;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [127:0] mem_line(input logic [15:0] a);
        logic [127:0] r;
        if (mmem.exists(a)) return mmem[a];
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = {a ^ 16'hA5A5, a + 16'(w)};
        return r;
    endfunction

    task automatic predict(input bit w, input logic [15:0] a, input logic [31:0] wd);
        logic [3:0]  i = a[5:2];
        logic [9:0]  t = a[15:6];
        int          o = int'(a[1:0]);
        bit          h = mv[i] && (mt[i] == t);
        logic [15:0] la = {t, i, 2'b00};
        logic [15:0] va;
        if (!h) begin
            if (mv[i] && mdirt[i]) begin
                va = {mt[i], i, 2'b00};
                expm.push_back('{1'b1, va, mdat[i]});
                mmem[va] = mdat[i];
            end
            expm.push_back('{1'b0, la, 128'h0});
            mdat[i] = mem_line(la);
            mt[i] = t;
            mv[i] = 1'b1;
            mdirt[i] = 1'b0;
        end
        if (w) begin
            mdat[i][o*32 +: 32] = wd;
            mdirt[i] = 1'b1;
        end
        expr.push_back('{mdat[i][o*32 +: 32], h});
    endtask

    task automatic start_req(input bit w, input logic [15:0] a, input logic [31:0] wd);
        bit ok = 0;
        predict(w, a, wd);
        @(posedge clk); #1;
        cpu_req_valid = 1'b1;
        cpu_req_write = w;
        cpu_req_addr  = a;
        cpu_req_wdata = wd;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cpu_req_ready) begin ok = 1; break; end
        end
        if (!ok) fail("accept_timeout");
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        cpu_req_wdata = $urandom();
    endtask

    task automatic do_req(input bit w, input logic [15:0] a, input logic [31:0] wd);
        int n0 = resp_cnt;
        start_req(w, a, wd);
        for (int k = 0; k < 400 && resp_cnt == n0; k++) @(negedge clk);
        if (resp_cnt == n0) fail("resp_timeout");
    endtask

    // Compare process and memory responder: outputs sampled on the falling edge
    initial begin
        mreq_t m;
        resp_t e;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
                fill_pend = 0; prev_stall = 0; prev_resp = 0; first_pending = 0;
                continue;
            end
            if (prev_resp) begin
                chk("resp_pulse", cpu_resp_valid, 1'b0);
                chk("ready_after_resp", cpu_req_ready, 1'b1);
            end
            if (cpu_resp_valid) begin
                if (expr.size() == 0) fail("unexpected_resp");
                else begin
                    e = expr.pop_front();
                    chk("resp_rdata", cpu_resp_rdata, e.rd);
                    chk("resp_hit", cpu_resp_hit, e.hit);
                    chk("resp_latency", cyc + 1, (e.hit ? acc_edge : fill_edge) + 2);
                end
                last_rdata = cpu_resp_rdata;
                last_hit   = cpu_resp_hit;
                resp_cnt++;
            end
            if (cpu_req_valid && cpu_req_ready) begin
                acc_edge = cyc + 1;
                first_pending = 1;
            end
            if (prev_stall) begin
                chk("req_stable_valid", mem_req_valid, 1'b1);
                chk("req_stable_addr", {mem_req_write, mem_req_addr}, {prev_write, prev_addr});
                chk("req_stable_wdata", mem_req_wdata, prev_wdata);
            end
            if (mem_req_valid) begin
                if (first_pending) begin
                    chk("mem_req_latency", cyc + 1, acc_edge + 2);
                    first_pending = 0;
                end
                if (expm.size() == 0) fail("unexpected_mem_req");
                else begin
                    chk("mem_req_write", mem_req_write, expm[0].w);
                    chk("mem_req_addr", mem_req_addr, expm[0].a);
                    if (expm[0].w) chk("mem_req_wdata", mem_req_wdata, expm[0].d);
                end
            end
            mem_resp_valid = 1'b0;
            mem_resp_rdata = {4{$urandom()}};
            if (fill_pend) begin
                if (fill_delay == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = mem_line(fill_addr);
                    fill_edge = cyc + 1;
                    fill_pend = 0;
                end else fill_delay--;
            end else if (spur_req) begin
                mem_resp_valid = 1'b1;
                spur_req = 0;
            end
            mem_req_ready = (force_low > 0 && mem_req_valid) ? 1'b0 : ($urandom_range(0, 1) == 1);
            if (force_low > 0 && mem_req_valid) force_low--;
            if (mem_req_valid && mem_req_ready && expm.size() > 0) begin
                m = expm.pop_front();
                if (m.w) begin
                    last_wb_addr = mem_req_addr;
                    last_wb_data = mem_req_wdata;
                end else begin
                    last_fill_addr = mem_req_addr;
                    fill_addr  = m.a;
                    fill_pend  = 1;
                    fill_delay = long_fill ? 20 : int'($urandom_range(0, 3));
                end
            end
            prev_stall = mem_req_valid && !mem_req_ready;
            prev_write = mem_req_write;
            prev_addr  = mem_req_addr;
            prev_wdata = mem_req_wdata;
            prev_resp  = cpu_resp_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ready"}, cpu_req_ready, 1'b1);
        chk({nm, "_resp"}, {cpu_resp_valid, cpu_resp_hit, cpu_resp_rdata}, 34'h0);
        chk({nm, "_mreq"}, {mem_req_valid, mem_req_write, mem_req_addr}, 18'h0);
        chk({nm, "_mwdata"}, mem_req_wdata, 128'h0);
    endtask

    initial begin
        int n0;
        resetn = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        mmem[16'h0040] = {32'h33, 32'h22, 32'h11, 32'h00};
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        resetn = 1'b1;

        do_req(1'b0, 16'h0041, 32'h0);
        chk("first_load_rdata", last_rdata, 32'h11);
        chk("first_load_hit", last_hit, 1'b0);
        chk("first_fill_addr", last_fill_addr, 16'h0040);

        do_req(1'b0, 16'h0043, 32'h0);
        chk("hit_load_rdata", last_rdata, 32'h33);
        chk("hit_load_hit", last_hit, 1'b1);

        do_req(1'b1, 16'h0042, 32'hDEADBEEF);
        chk("hit_store_rdata", last_rdata, 32'hDEADBEEF);

        force_low = 5;
        do_req(1'b0, 16'h0440, 32'h0);
        chk("wb_addr", last_wb_addr, 16'h0040);
        chk("wb_word2", last_wb_data[95:64], 32'hDEADBEEF);
        chk("evict_fill_addr", last_fill_addr, 16'h0440);
        chk("evict_hit", last_hit, 1'b0);

        n0 = resp_cnt;
        @(posedge clk); #1;
        spur_req = 1;
        repeat (4) @(negedge clk);
        chk("spur_no_resp", resp_cnt, n0);
        chk("spur_ready", cpu_req_ready, 1'b1);
        do_req(1'b0, 16'h0441, 32'h0);
        chk("after_spur_hit", last_hit, 1'b1);

        for (int k = 0; k < 300; k++)
            do_req($urandom_range(0, 1) == 1,
                   {8'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                   $urandom());

        long_fill = 1;
        start_req(1'b0, 16'hFC01, 32'h0);
        for (int k = 0; k < 200 && !fill_pend; k++) @(negedge clk);
        if (!fill_pend) fail("fill_wait_timeout");
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1 chk_reset_outputs("mid_fill_reset");
        expm.delete();
        expr.delete();
        for (int i = 0; i < 16; i++) begin mv[i] = 0; mdirt[i] = 0; end
        long_fill = 0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        do_req(1'b0, 16'h0041, 32'h0);
        chk("reload_after_reset_hit", last_hit, 1'b0);

        repeat (3) @(negedge clk);
        chk("leftover_expectations", expm.size() + expr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
